nibble_serial_adder: RTL
========================

// Module: nibble_serial_adder
// PURPOSE
//   Multi-cycle WIDTH-bit adder that wraps one 4-bit ripple_carry_adder slice.
//   Accepts an operand pair over a valid/ready handshake and feeds the slice one
//   nibble per cycle, LSB first, with the carry held in a register between nibbles.
//   Collects the sum nibbles and presents the result over a valid/ready handshake.
//   Sits both upstream (operand sequencing) and downstream (result collection) of the slice.
// PARAMETERS
//   WIDTH   16   operand/result width; must be a multiple of 4 and >= 8
//   (localparam NIB = WIDTH/4: number of nibble passes)
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      operand pair a/b/cin is valid
//   in_ready   out  1      block can accept operands (high only in IDLE)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry into nibble 0
//   out_valid  out  1      sum/cout are valid (high only in DONE)
//   out_ready  in   1      consumer accepts the result
//   sum        out  WIDTH  result, low WIDTH bits of a+b+cin
//   cout       out  1      carry out of the MSB nibble
//   ovf        out  1      signed overflow (present only with RCA_OVF_EN)
// BEHAVIOUR
//   - Reset (async, any state): state=IDLE, nibble index=0, carry reg=0, sum=0,
//     cout=0, out_valid=0, operand regs=0; ovf=0 when present. in_ready=1 after reset.
//   - FSM states: IDLE, RUN, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
//   - IDLE: if in_valid, capture a, b, and cin into the carry reg; clear index; go to RUN.
//   - RUN: each cycle the slice adds a[4i+3:4i] + b[4i+3:4i] + carry reg.
//     Write the slice sum into sum[4i+3:4i] and load the slice cout into the carry reg.
//     Increment i. On i==NIB-1, load cout from the slice, go to DONE, and reset i to 0.
//   - DONE: hold sum, cout and ovf stable while out_ready=0. On out_ready=1, go to IDLE.
//   - Latency: handshake edge at cycle 0 -> out_valid high at cycle NIB.
//     Minimum issue interval is NIB+2 cycles.
//   - in_valid while not in IDLE is ignored, with no capture and no side effect.
//     Operands are registered at accept; later changes on a/b do not affect the result.
//   - DONE with out_ready=1 and in_valid=1 in the same cycle: the operands are not
//     accepted (in_ready=0). They are accepted on the next cycle in IDLE.
//   - sum is not cleared between operations. Nibbles are overwritten during RUN, and sum
//     is meaningful only while out_valid=1.
//   - Wrap-around: the result is modulo 2^WIDTH. The carry beyond the MSB is reported
//     only on cout.
//   - Reset mid-RUN/DONE: the operation is discarded and no out_valid pulse occurs.
// CONFIGURATION
//   RCA_OVF_EN defined:
//     - Port ovf exists.
//     - Set on entry to DONE: ovf = (a[W-1] ~^ b[W-1]) & (sum[W-1] ^ a[W-1]).
//     - Held with sum.
//   RCA_OVF_EN undefined:
//     - Port ovf and its logic are absent.
//     - All other behaviour is identical.
// TESTING (WIDTH=16)
//   1. Assert rst mid-cycle, no clock edge -> out_valid=0, sum=0, cout=0, in_ready=1 immediately.
//   2. a=16'h1234, b=16'h4321, cin=0 -> out_valid 4 cycles after accept, sum=16'h5555, cout=0.
//   3. a=16'hFFFF, b=16'h0001, cin=0 -> carry ripples through all 4 nibbles;
//      sum=16'h0000, cout=1, ovf=0.
//   4. a=16'h7FFF, b=16'h0000, cin=1 -> sum=16'h8000, cout=0, ovf=1 (RCA_OVF_EN build).
//   5. Result 16'h5555 with out_ready=0 for 5 cycles while in_valid=1 with new operands
//      -> sum held, in_ready=0, nothing captured. Then raise out_ready
//      -> IDLE next cycle, new operands accepted.
//   6. Accept a=16'hFFFF, b=16'hFFFF, then pulse rst after 2 RUN cycles -> no out_valid,
//      IDLE. Then a=16'h0F0F, b=16'h00F1, cin=0 -> sum=16'h1000, cout=0.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - multi-cycle WIDTH-bit adder over a 4-bit ripple-carry slice
// Optional signed-overflow output: define RCA_OVF_EN.

module ripple_carry_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[4];
    end
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef RCA_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = $clog2(NIB);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [IW-1:0]     idx;
    logic              carry;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [3:0]        s_sum;
    logic              s_cout;
    logic              last;

    assign last      = (idx == IW'(NIB - 1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Nibble i of each operand is selected by shifting the index left by two.
    ripple_carry_adder u_slice (
        .a    (a_q[{idx, 2'b00} +: 4]),
        .b    (b_q[{idx, 2'b00} +: 4]),
        .cin  (carry),
        .sum  (s_sum),
        .cout (s_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef RCA_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        carry <= cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    sum[{idx, 2'b00} +: 4] <= s_sum;
                    carry                  <= s_cout;
                    if (last) begin
                        idx  <= '0;
                        cout <= s_cout;
`ifdef RCA_OVF_EN
                        // Top sum bit comes straight from the slice on this final pass.
                        ovf  <= (a_q[WIDTH-1] ~^ b_q[WIDTH-1]) & (s_sum[3] ^ a_q[WIDTH-1]);
`endif
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
